// File: rtl/wb_lsu_pkg.sv
// Shared definitions for the Wishbone load/store unit: size codes, FSM encodings and
// small helpers for access width, alignment checking and load extension.
package wb_lsu_pkg;

  localparam int unsigned Xlen = 64;

  localparam logic [1:0] SzB = 2'b00;
  localparam logic [1:0] SzH = 2'b01;
  localparam logic [1:0] SzW = 2'b10;
  localparam logic [1:0] SzD = 2'b11;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StErr   = 3'd3;
  localparam logic [2:0] StFin   = 3'd4;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr);
    logic m;
    unique case (size)
      SzB:     m = 1'b0;
      SzH:     m = addr[0];
      SzW:     m = |addr[1:0];
      default: m = |addr;
    endcase
    return m;
  endfunction

  function automatic logic [Xlen-1:0] extend(input logic [Xlen-1:0] v, input logic [1:0] size,
                                             input logic uns);
    logic [Xlen-1:0] r;
    unique case (size)
      SzB:     r = {{56{~uns & v[7]}}, v[7:0]};
      SzH:     r = {{48{~uns & v[15]}}, v[15:0]};
      SzW:     r = {{32{~uns & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_lsu_if.sv
// Pipelined Wishbone B.4 master/slave bundle carrying one load/store unit's data bus.
interface wb_lsu_if #(
  parameter int unsigned BusW = 16
) ();
  localparam int unsigned Bb = BusW / 8;

  logic [63:0]     adr;
  logic [BusW-1:0] dat_w;
  logic [BusW-1:0] dat_r;
  logic            we;
  logic [Bb-1:0]   sel;
  logic            stb;
  logic            cyc;
  logic            stall;
  logic            ack;
  logic            err;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  stall, ack, err, dat_r
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output stall, ack, err, dat_r
  );
endinterface

// File: rtl/wb_lsu_lane.sv
// Byte-lane steering: store data and selects for the current beat, and extraction plus
// sign/zero extension of the assembled load data.
module wb_lsu_lane
  import wb_lsu_pkg::*;
#(
  parameter int unsigned BUS_W = 16
) (
  input  logic [1:0]         size_i,
  input  logic               unsigned_i,
  input  logic [2:0]         addr_lo_i,
  input  logic [1:0]         beat_i,
  input  logic [Xlen-1:0]    wdat_i,
  input  logic [Xlen-1:0]    stage_i,
  output logic [BUS_W-1:0]   wdat_o,
  output logic [BUS_W/8-1:0] sel_o,
  output logic [Xlen-1:0]    ldat_o
);
  localparam int unsigned Bb = BUS_W / 8;

  logic [2:0] off;
  logic [7:0] bmask;
  logic       wide;

  // Accesses at least one bus word wide are aligned, so their lane offset is always zero.
  assign off   = addr_lo_i & 3'(Bb - 1);
  assign wide  = 32'(size_bytes(size_i)) >= Bb;
  assign bmask = 8'((9'd1 << size_bytes(size_i)) - 9'd1);

  always_comb begin
    if (wide) begin
      wdat_o = BUS_W'(wdat_i >> (32'(beat_i) * BUS_W));
      sel_o  = '1;
    end else begin
      wdat_o = BUS_W'(wdat_i << (32'(off) * 8));
      sel_o  = Bb'(16'(bmask) << off);
    end
    ldat_o = extend(stage_i >> (32'(off) * 8), size_i, unsigned_i);
  end

endmodule

// File: rtl/wb_lsu.sv
// Load/store unit: splits one pipeline request into pipelined Wishbone beats, tracks
// outstanding beats, assembles load data and reports completion or fault with one pulse.
module wb_lsu
  import wb_lsu_pkg::*;
#(
  parameter int unsigned BUS_W  = 16,
  parameter int unsigned MAX_OS = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic            nomem_i,
  input  logic [Xlen-1:0] addr_i,
  input  logic [Xlen-1:0] dat_i,
  output logic            busy_o,
  output logic            rwe_o,
  output logic            done_o,
  output logic            fault_o,
  output logic [Xlen-1:0] dat_o,
  wb_lsu_if.master        wb
);
  localparam int unsigned Bb       = BUS_W / 8;
  localparam int unsigned OffW     = $clog2(Bb);
  localparam int unsigned MaxBeats = Xlen / BUS_W;
  localparam int unsigned BeatW    = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;
  localparam int unsigned OsW      = $clog2(MAX_OS + 1);

  logic [2:0]       state_q, state_d;
  logic             cyc_q, cyc_d, stb_q, stb_d;
  logic [BeatW-1:0] beat_q, beat_d, last_q, last_d, rsp_q, rsp_d;
  logic [OsW-1:0]   os_q, os_d;
  logic             we_q, we_d, uns_q, uns_d;
  logic [1:0]       size_q, size_d;
  logic [Xlen-1:0]  addr_q, addr_d, wdat_q, wdat_d, stage_q, stage_d, dat_q, dat_d;
  logic             rwe_q, rwe_d, done_q, done_d, fault_q, fault_d;

  logic             accept, rsp_ok, err_v, ack_v;
  logic             go_err, fin_ok, fin_err;
  logic [31:0]      req_bytes;
  logic [BUS_W-1:0] lane_wdat;
  logic [Bb-1:0]    lane_sel;
  logic [Xlen-1:0]  lane_ldat;

  // Responses with nothing outstanding are stray and ignored; err wins over ack.
  always_comb begin
    accept  = stb_q & ~wb.stall;
    rsp_ok  = (os_q != '0);
    err_v   = wb.err & rsp_ok;
    ack_v   = wb.ack & ~wb.err & rsp_ok;
    os_d    = os_q + OsW'(accept) - OsW'(err_v | ack_v);
    stage_d = stage_q;
    rsp_d   = rsp_q;
    if (state_q == StIdle) begin
      stage_d = '0;
      rsp_d   = '0;
    end else if (ack_v) begin
      for (int k = 0; k < MaxBeats; k++) begin
        if (rsp_q == BeatW'(k)) stage_d[k*BUS_W +: BUS_W] = wb.dat_r;
      end
      rsp_d = rsp_q + BeatW'(1);
    end
  end

  assign req_bytes = 32'(size_bytes(size_i));

  wb_lsu_lane #(
    .BUS_W(BUS_W)
  ) u_lane (
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .addr_lo_i (addr_q[2:0]),
    .beat_i    (2'(beat_q)),
    .wdat_i    (wdat_q),
    .stage_i   (stage_d),
    .wdat_o    (lane_wdat),
    .sel_o     (lane_sel),
    .ldat_o    (lane_ldat)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    beat_d  = beat_q;
    last_d  = last_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    dat_d   = dat_q;
    rwe_d   = 1'b0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    go_err  = 1'b0;
    fin_ok  = 1'b0;
    fin_err = 1'b0;

    case (state_q)
      StIdle: begin
        if (nomem_i) begin
          dat_d   = addr_i;
          rwe_d   = 1'b1;
          state_d = StFin;
        end else if (req_i) begin
          we_d   = we_i;
          size_d = size_i;
          uns_d  = unsigned_i;
          addr_d = addr_i;
          wdat_d = dat_i;
          beat_d = '0;
          last_d = (req_bytes > Bb) ? BeatW'(req_bytes / Bb - 1) : '0;
          if (misaligned(size_i, addr_i[2:0])) begin
            fault_d = 1'b1;
            state_d = StFin;
          end else begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (err_v) begin
          go_err = 1'b1;
        end else if (accept && beat_q == last_q) begin
          stb_d   = 1'b0;
          state_d = StDrain;
        end else begin
          if (accept) beat_d = beat_q + BeatW'(1);
          // Hold off strobing while the slave owes us MAX_OS responses.
          stb_d = (os_d != OsW'(MAX_OS));
        end
      end
      StDrain: begin
        if (err_v) go_err = 1'b1;
        else if (os_d == '0) fin_ok = 1'b1;
      end
      StErr: begin
        if (os_d == '0) fin_err = 1'b1;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (go_err) begin
      stb_d = 1'b0;
      if (os_d == '0) fin_err = 1'b1;
      else state_d = StErr;
    end
    if (fin_ok || fin_err) begin
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      state_d = StFin;
    end
    if (fin_ok) begin
      done_d = 1'b1;
      if (!we_q) begin
        rwe_d = 1'b1;
        dat_d = lane_ldat;
      end
    end
    if (fin_err) fault_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      beat_q  <= '0;
      last_q  <= '0;
      rsp_q   <= '0;
      os_q    <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      stage_q <= '0;
      dat_q   <= '0;
      rwe_q   <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      rsp_q   <= rsp_d;
      os_q    <= os_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      stage_q <= stage_d;
      dat_q   <= dat_d;
      rwe_q   <= rwe_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign wb.cyc   = cyc_q;
  assign wb.stb   = stb_q;
  assign wb.we    = stb_q & we_q;
  assign wb.sel   = stb_q ? lane_sel : '0;
  assign wb.dat_w = lane_wdat;
  assign wb.adr   = {addr_q[Xlen-1:OffW], {OffW{1'b0}}} + (Xlen'(beat_q) << OffW);

  assign busy_o  = cyc_q | (state_q == StFin);
  assign rwe_o   = rwe_q;
  assign done_o  = done_q;
  assign fault_o = fault_q;
  assign dat_o   = dat_q;

endmodule
